// File: rtl/ram_fifo_pkg.sv
// Shared defaults and types for the RAM-backed ready/valid FIFO controller.
package ram_fifo_pkg;

   localparam int DEF_DATA_W = 72;
   localparam int DEF_ADDR_W = 2;
   localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

   // Output stage: either the registered RAM read data holds a live word or it does not.
   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_VALID = 1'b1
   } out_state_t;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Write/read pointers and resident-word count for the RAM-backed FIFO.
// Writes and reads never coincide, so the count moves by at most one per cycle.
module fifo_ptr_cnt #(
   parameter int ADDR_W = ram_fifo_pkg::DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_acc,
   input  logic              rd_issue,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic [ADDR_W-1:0] rd_ptr,
   output logic [ADDR_W:0]   mem_cnt
);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;

   // Next-state: pointers wrap naturally at DEPTH, count follows the single active op.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         cnt_d    = cnt_q + 1'b1;
      end
      if (rd_issue) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         cnt_d    = cnt_q - 1'b1;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign wr_ptr  = wr_ptr_q;
   assign rd_ptr  = rd_ptr_q;
   assign mem_cnt = cnt_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Ready/valid FIFO controller driving a single-port synchronous RAM.
// Reads take priority over writes; the RAM's registered read data is the output
// stage, so a read is only issued when that stage is free or being drained.
module ram_fifo_ctrl
   import ram_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_enb,
   output logic              ram_wr,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [ADDR_W:0]   mem_cnt,
   output logic              full,
   output logic              empty
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(2 ** ADDR_W);

   out_state_t        state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              rd_issue, wr_acc;

   fifo_ptr_cnt #(.ADDR_W(ADDR_W)) u_ptr_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_acc   (wr_acc),
      .rd_issue (rd_issue),
      .wr_ptr   (wr_ptr),
      .rd_ptr   (rd_ptr),
      .mem_cnt  (mem_cnt)
   );

   // Port arbitration: read whenever RAM has data and the output stage can take it.
   always_comb begin
      rd_issue = (mem_cnt != '0) && ((state_q == OUT_EMPTY) || out_ready);
      full     = (mem_cnt == DEPTH_CNT);
      in_ready = !full && !rd_issue;
      wr_acc   = in_valid && in_ready;
      ram_enb  = rd_issue || wr_acc;
      ram_wr   = wr_acc;
      ram_addr = rd_issue ? rd_ptr : wr_ptr;
   end

   // Output-stage next state: a read always refills it, a take without refill empties it.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         OUT_EMPTY: if (rd_issue) state_d = OUT_VALID;
         OUT_VALID: if (out_ready && !rd_issue) state_d = OUT_EMPTY;
         default:   state_d = OUT_EMPTY;
      endcase
   end

   // Output-stage register; reset drops any word held in the RAM read register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= OUT_EMPTY;
      else        state_q <= state_d;
   end

   assign out_valid = (state_q == OUT_VALID);
   assign out_data  = ram_rdata;
   assign ram_data  = in_data;
   assign empty     = (mem_cnt == '0) && !out_valid;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural single-port RAM, a
// cycle-level occupancy model and a scoreboard queue of expected output words.
module tb_ram_fifo_ctrl;

   localparam int DW = 72;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data, ram_data, ram_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_enb, ram_wr, full, empty;
   logic [AW:0]   mem_cnt;

   logic [DW-1:0] ram_mem [4];

   int            tests = 0;
   int            fails = 0;
   int            pops  = 0;

   // Reference model state
   int            m_cnt = 0;
   bit            m_ov  = 1'b0;
   logic [AW-1:0] m_wp  = '0;
   logic [AW-1:0] m_rp  = '0;
   bit            m_init = 1'b0;
   logic [DW-1:0] sb[$];

   always #5 clk = ~clk;

   ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_enb(ram_enb), .ram_wr(ram_wr),
      .ram_rdata(ram_rdata), .mem_cnt(mem_cnt), .full(full), .empty(empty)
   );

   // Behavioural RAM: write on enb&wr, registered read on enb&!wr, read data holds otherwise.
   always @(posedge clk) begin
      if (ram_enb && ram_wr)  ram_mem[ram_addr] <= ram_data;
      if (ram_enb && !ram_wr) ram_rdata <= ram_mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      tests++;
      fails++;
      $display("FAIL %s: cycle budget expired", tag);
   endtask

   // One clock cycle: check DUT against the model with current inputs, record
   // handshakes in the scoreboard, advance the model at the edge, return at negedge.
   task automatic cycle(output bit acc);
      bit m_rd, m_inr, m_wr;
      logic [DW-1:0] exp;
      #1;
      m_rd  = (m_cnt != 0) && (!m_ov || out_ready);
      m_inr = (m_cnt != 4) && !m_rd;
      m_wr  = in_valid && m_inr;
      acc   = rst_n && m_init && m_wr;
      if (rst_n && m_init) begin
         chk("in_ready", in_ready, m_inr);
         chk("out_valid", out_valid, m_ov);
         chk("mem_cnt", mem_cnt, m_cnt);
         chk("full", full, m_cnt == 4);
         chk("empty", empty, (m_cnt == 0) && !m_ov);
         chk("ram_enb", ram_enb, m_rd || m_wr);
         if (m_rd || m_wr) begin
            chk("ram_wr", ram_wr, m_wr);
            chk("ram_addr", ram_addr, m_rd ? m_rp : m_wp);
         end
         if (m_wr) sb.push_back(in_data);
         if (m_ov && out_ready) begin
            if (sb.size() == 0) begin
               timeout("pop_unexpected");
            end else begin
               exp = sb.pop_front();
               chk("out_data", out_data, exp);
               pops++;
               $display("[TB] pop %h", out_data);
            end
         end
      end
      @(posedge clk);
      if (!rst_n) begin
         m_cnt = 0; m_ov = 0; m_wp = '0; m_rp = '0; m_init = 1'b1;
         sb.delete();
      end else if (m_init) begin
         if (m_wr) begin m_cnt++; m_wp = m_wp + 1'b1; end
         if (m_rd) begin m_cnt--; m_rp = m_rp + 1'b1; end
         if (m_rd) m_ov = 1'b1;
         else if (out_ready) m_ov = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      bit acc;
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      do begin
         cycle(acc);
         n++;
      end while (!acc && n < 50);
      if (!acc) timeout("push");
      in_valid = 1'b0;
   endtask

   initial begin
      bit            acc;
      int            n, idx, p0;
      logic [DW-1:0] held;
      logic [DW-1:0] seq2 [5];
      seq2 = '{72'hA1, 72'hA2, 72'hA3, 72'hA4, 72'hA5};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      cycle(acc);
      cycle(acc);
      rst_n = 1'b1;

      // 1. Idle after reset
      repeat (10) begin
         cycle(acc);
         chk("idle_in_ready", in_ready, 1'b1);
         chk("idle_ram_enb", ram_enb, 1'b0);
      end

      // 2. Fill with consumer stalled
      out_ready = 1'b0;
      foreach (seq2[i]) push_word(seq2[i]);
      chk("fill_full", full, 1'b1);
      chk("fill_in_ready", in_ready, 1'b0);
      chk("fill_mem_cnt", mem_cnt, 3'd4);
      chk("fill_out_valid", out_valid, 1'b1);
      chk("fill_out_data", out_data, 72'hA1);
      in_valid = 1'b1;
      in_data  = 72'hA6;
      repeat (3) begin
         cycle(acc);
         chk("a6_held", acc, 1'b0);
      end

      // 3. Drain; A6 enters once the RAM has emptied
      out_ready = 1'b1;
      p0 = pops;
      n  = 0;
      do begin
         cycle(acc);
         n++;
      end while (!acc && n < 20);
      if (!acc) timeout("a6_accept");
      in_valid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         cycle(acc);
         n++;
      end
      chk("drain_pops", pops - p0, 6);
      chk("drain_empty", empty, 1'b1);

      // 4. Wrap with random handshakes
      idx = 0;
      n   = 0;
      p0  = pops;
      while ((idx < 12 || sb.size() != 0) && n < 500) begin
         in_valid  = (idx < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
         in_data   = DW'(32'h100 + idx);
         out_ready = 1'($urandom_range(0, 1));
         cycle(acc);
         if (acc) idx++;
         n++;
      end
      if (n >= 500) timeout("wrap_stream");
      in_valid = 1'b0;
      chk("wrap_pops", pops - p0, 12);

      // 5. Backpressure with two words resident
      out_ready = 1'b1;
      cycle(acc);
      cycle(acc);
      out_ready = 1'b0;
      push_word(72'h200);
      push_word(72'h201);
      push_word(72'h202);
      chk("bp_mem_cnt", mem_cnt, 3'd2);
      chk("bp_out_valid", out_valid, 1'b1);
      held = out_data;
      chk("bp_head", held, 72'h200);
      repeat (5) begin
         cycle(acc);
         chk("bp_no_read", ram_enb && !ram_wr, 1'b0);
         chk("bp_stable", out_data, held);
      end

      // 6. Reset mid-stream
      push_word(72'h203);
      chk("pre_rst_mem_cnt", mem_cnt, 3'd3);
      rst_n = 1'b0;
      cycle(acc);
      rst_n = 1'b1;
      chk("rst_mem_cnt", mem_cnt, 3'd0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_empty", empty, 1'b1);
      out_ready = 1'b1;
      push_word(72'h55);
      chk("post_rst_rd_enb", ram_enb, 1'b1);
      chk("post_rst_rd_wr", ram_wr, 1'b0);
      chk("post_rst_rd_addr", ram_addr, 2'd0);
      p0 = pops;
      cycle(acc);
      cycle(acc);
      chk("post_rst_pop", pops - p0, 1);
      chk("post_rst_empty", empty, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
